sd_spi_tx_ctrl: RTL and testbench

Byte-level transmit controller for the SD-card SPI link. It sits directly upstream of the parallel-to-serial shift register and drives that register's `load_enable`, `shift_enable` and `parallel_in`. It accepts bytes over a valid/ready handshake and generates SCLK at a divided rate, shifting MSB-first. It also frames chip-select and produces the ≥74-clock SD power-up dummy sequence. Command and data framing logic sits upstream of this block; the MOSI bit is the shift register's `serial_out`.

---
 rtl/sd_spi_pkg.sv | 22 ++
 rtl/sd_spi_tx_ctrl_timer.sv | 36 +++
 rtl/sd_spi_tx_ctrl.sv | 176 +++++++++++++++++
 tb/tb_sd_spi_tx_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_spi_pkg.sv
// Shared types and default constants for the SD-card SPI transmit path.
package sd_spi_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      INIT  = 3'd1,
      SHIFT = 3'd2,
      WAIT  = 3'd3,
      HOLD  = 3'd4
   } tx_state_t;

   localparam int DATA_BITS_DEF = 8;
   localparam int SCLK_DIV_DEF  = 4;
   localparam int INIT_CLKS_DEF = 80;
   localparam int CS_HOLD_DEF   = 2;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sd_spi_tx_ctrl_timer.sv
// SCLK phase timer: counts system clocks within one SCLK period while run
// is high, flags the last cycle of the period and decodes the high half.
module spi_bit_timer
   import sd_spi_pkg::*;
#(
   parameter int CLK_DIV = SCLK_DIV_DEF
) (
   input  logic clk,
   input  logic n_rst,
   input  logic run,
   output logic tc,
   output logic sclk_hi
);

   localparam int DW = cnt_width(CLK_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

   logic [DW-1:0] div_cnt;

   // Free-running divider while enabled; parked at zero otherwise so every
   // new byte or init sequence starts on a fresh SCLK-low phase.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         div_cnt <= '0;
      end else if (!run || tc) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   assign tc      = run && (div_cnt == DIV_LAST);
   assign sclk_hi = run && (div_cnt >= DIV_HALF);

endmodule

// File: rtl/sd_spi_tx_ctrl.sv
// Byte-level SPI transmit controller: drives the external shift register,
// generates SCLK (mode 0), frames cs_n and runs the SD power-up dummy clocks.
//
//  state | meaning
//  IDLE  | cs_n high, ready for a byte or an init request
//  INIT  | dummy clocks with cs_n high and MOSI held at 1
//  SHIFT | shifting one byte out, cs_n low
//  WAIT  | underrun between bytes of a frame, cs_n kept low
//  HOLD  | cs_n hold time after the last byte of a frame
module sd_spi_tx_ctrl
   import sd_spi_pkg::*;
#(
   parameter int DATA_BITS = DATA_BITS_DEF,
   parameter int CLK_DIV   = SCLK_DIV_DEF,
   parameter int INIT_CLKS = INIT_CLKS_DEF,
   parameter int CS_HOLD   = CS_HOLD_DEF
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   input  logic                 tx_last,
   input  logic                 init_req,
   output logic                 tx_ready,
   output logic                 sr_load,
   output logic                 sr_shift,
   output logic [DATA_BITS-1:0] sr_data,
   output logic                 sclk,
   output logic                 cs_n,
   output logic                 busy,
   output logic                 byte_done
);

   localparam int BW = cnt_width(DATA_BITS);
   localparam int IW = cnt_width(INIT_CLKS);
   localparam int HW = cnt_width(CS_HOLD);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
   localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CLKS - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(CS_HOLD - 1);

   tx_state_t     state, state_nxt;
   logic [BW-1:0] bit_cnt;
   logic [IW-1:0] init_cnt;
   logic [HW-1:0] hold_cnt;
   logic          last_q;
   logic          accept;
   logic          run;
   logic          tc;
   logic          sclk_hi;

   assign run  = (state == SHIFT) || (state == INIT);
   assign busy = (state != IDLE);

   spi_bit_timer #(
      .CLK_DIV (CLK_DIV)
   ) u_bit_timer (
      .clk     (clk),
      .n_rst   (n_rst),
      .run     (run),
      .tc      (tc),
      .sclk_hi (sclk_hi)
   );

   // State register; async reset makes cs_n rise immediately.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Bit, init and hold counters plus the frame-end flag of the current byte.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         bit_cnt  <= '0;
         init_cnt <= '0;
         hold_cnt <= '0;
         last_q   <= 1'b0;
      end else begin
         if (accept) begin
            bit_cnt <= '0;
            last_q  <= tx_last;
         end else if (sr_shift) begin
            bit_cnt <= bit_cnt + 1'b1;
         end

         if (state != INIT) begin
            init_cnt <= '0;
         end else if (tc) begin
            init_cnt <= (init_cnt == INIT_LAST) ? '0 : init_cnt + 1'b1;
         end

         if (state != HOLD) begin
            hold_cnt <= '0;
         end else begin
            hold_cnt <= (hold_cnt == HOLD_LAST) ? '0 : hold_cnt + 1'b1;
         end
      end
   end

   // Next-state and output decode. The end-of-byte cycle never shifts: the
   // following load (back-to-back) or HOLD/WAIT replaces the exhausted byte.
   always_comb begin
      state_nxt = state;
      tx_ready  = 1'b0;
      accept    = 1'b0;
      sr_load   = 1'b0;
      sr_shift  = 1'b0;
      sr_data   = tx_data;
      sclk      = 1'b0;
      cs_n      = 1'b1;
      byte_done = 1'b0;
      unique case (state)
         IDLE: begin
            if (init_req) begin
               sr_load   = 1'b1;
               sr_data   = '1;
               state_nxt = INIT;
            end else begin
               tx_ready = 1'b1;
               if (tx_valid) begin
                  accept    = 1'b1;
                  state_nxt = SHIFT;
               end
            end
         end
         INIT: begin
            sclk = sclk_hi;
            if (tc && (init_cnt == INIT_LAST)) begin
               state_nxt = IDLE;
            end
         end
         SHIFT: begin
            cs_n = 1'b0;
            sclk = sclk_hi;
            if (tc) begin
               if (bit_cnt != BIT_LAST) begin
                  sr_shift = 1'b1;
               end else begin
                  byte_done = 1'b1;
                  if (last_q) begin
                     state_nxt = HOLD;
                  end else begin
                     tx_ready = 1'b1;
                     if (tx_valid) begin
                        accept = 1'b1;
                     end else begin
                        state_nxt = WAIT;
                     end
                  end
               end
            end
         end
         WAIT: begin
            cs_n     = 1'b0;
            tx_ready = 1'b1;
            if (tx_valid) begin
               accept    = 1'b1;
               state_nxt = SHIFT;
            end
         end
         HOLD: begin
            cs_n = 1'b0;
            if (hold_cnt == HOLD_LAST) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (accept) begin
         sr_load = 1'b1;
      end
   end

endmodule

// File: tb/tb_sd_spi_tx_ctrl.sv
// Testbench for sd_spi_tx_ctrl: behavioural shift register, SPI receiver
// monitor with expected-byte scoreboard, directed timing and random frames.
module tb_sd_spi_tx_ctrl;

   localparam int DB        = 8;
   localparam int CLK_DIV   = 4;
   localparam int INIT_CLKS = 80;
   localparam int CS_HOLD   = 2;
   localparam int P         = DB * CLK_DIV;
   localparam int BUDGET    = 1000;

   logic          clk = 1'b0;
   logic          n_rst = 1'b0;
   logic [DB-1:0] tx_data = '0;
   logic          tx_valid = 1'b0;
   logic          tx_last = 1'b0;
   logic          init_req = 1'b0;
   logic          tx_ready, sr_load, sr_shift, sclk, cs_n, busy, byte_done;
   logic [DB-1:0] sr_data;
   logic [DB-1:0] sr;
   logic          mosi;

   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            frames = 0;
   int            frames_exp = 0;
   logic [DB-1:0] exp_q[$];

   sd_spi_tx_ctrl #(
      .DATA_BITS (DB),
      .CLK_DIV   (CLK_DIV),
      .INIT_CLKS (INIT_CLKS),
      .CS_HOLD   (CS_HOLD)
   ) dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_last   (tx_last),
      .init_req  (init_req),
      .tx_ready  (tx_ready),
      .sr_load   (sr_load),
      .sr_shift  (sr_shift),
      .sr_data   (sr_data),
      .sclk      (sclk),
      .cs_n      (cs_n),
      .busy      (busy),
      .byte_done (byte_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Downstream parallel-to-serial register, MSB first.
   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) sr <= '0;
      else if (sr_load) sr <= sr_data;
      else if (sr_shift) sr <= {sr[DB-2:0], 1'b0};
   end
   assign mosi = sr[DB-1];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: behaves as the card, sampling MOSI on SCLK rising edges while
   // selected, and checks each completed byte against the scoreboard.
   initial begin : monitor
      logic          prev_sclk;
      logic          prev_cs;
      logic [DB-1:0] rx;
      logic [DB-1:0] e;
      int            nbits;
      prev_sclk = 1'b0;
      prev_cs   = 1'b1;
      rx        = '0;
      nbits     = 0;
      forever begin
         @(negedge clk);
         if (!n_rst) begin
            nbits     = 0;
            prev_sclk = 1'b0;
            prev_cs   = 1'b1;
         end else begin
            if (sclk && !prev_sclk && !cs_n) begin
               rx = {rx[DB-2:0], mosi};
               nbits++;
            end
            if (byte_done) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL rx_byte: got %0h but no byte expected", rx);
               end else begin
                  e = exp_q.pop_front();
                  chk("rx_byte", rx, e);
                  chk("rx_bits", nbits, DB);
               end
               nbits = 0;
            end
            if (cs_n && !prev_cs) frames++;
            prev_sclk = sclk;
            prev_cs   = cs_n;
         end
      end
   end

   // Expected {sr_load, sr_shift, sclk, cs_n, byte_done} at cycle k of a
   // lone last byte accepted from IDLE at cycle 0.
   function automatic logic [4:0] exp_vec(input int k);
      logic ld, sh, sc, cs, bd;
      ld = (k == 0);
      sh = (k >= CLK_DIV) && (k <= (DB - 1) * CLK_DIV) && (k % CLK_DIV == 0);
      sc = (k >= 1) && (k <= P) && (((k - 1) % CLK_DIV) >= CLK_DIV / 2);
      cs = !((k >= 1) && (k <= P + CS_HOLD));
      bd = (k == P);
      return {ld, sh, sc, cs, bd};
   endfunction

   // Present a byte (called just after a rising edge) and hold it until
   // accepted; returns the acceptance cycle.
   task automatic drive_byte(input logic [DB-1:0] d, input logic last, output int acc);
      bit ok;
      ok       = 1'b0;
      acc      = -1;
      tx_data  = d;
      tx_last  = last;
      tx_valid = 1'b1;
      for (int i = 0; i < BUDGET; i++) begin
         @(negedge clk);
         if (tx_ready) begin
            ok  = 1'b1;
            acc = cyc;
            exp_q.push_back(d);
            if (last) frames_exp++;
            break;
         end
      end
      if (!ok) chk("accept_timeout", 0, 1);
      @(posedge clk);
      #1 tx_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < BUDGET; i++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("idle_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #2ms;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int            a1, a2, t0, rises, bad, nb, gap;
      logic          ps;
      logic [DB-1:0] d;

      // Reset values
      #2;
      chk("reset_outs", {cs_n, sclk, sr_load, sr_shift, byte_done, busy, tx_ready}, 7'b1000001);
      @(posedge clk);
      #1 n_rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Single byte 0xA5 (last), full cycle-accurate framing
      tx_data  = 8'hA5;
      tx_last  = 1'b1;
      tx_valid = 1'b1;
      for (int k = 0; k <= P + CS_HOLD + 1; k++) begin
         @(negedge clk);
         if (k == 0 && tx_ready) begin
            exp_q.push_back(8'hA5);
            frames_exp++;
         end
         chk($sformatf("single_c%0d", k), {sr_load, sr_shift, sclk, cs_n, byte_done}, exp_vec(k));
         if (k == 0) begin
            @(posedge clk);
            #1 tx_valid = 1'b0;
         end
      end
      wait_idle();

      // Back-to-back with tx_valid held high
      drive_byte(8'h3C, 1'b0, a1);
      drive_byte(8'hFF, 1'b1, a2);
      chk("b2b_gap", a2 - a1, P);
      wait_idle();

      // Underrun: WAIT keeps cs_n low and sclk idle
      drive_byte(8'h12, 1'b0, a1);
      bad = 1;
      for (int i = 0; i < BUDGET; i++) begin
         @(negedge clk);
         if (byte_done) begin
            bad = 0;
            break;
         end
      end
      chk("underrun_byte_done", bad, 0);
      @(posedge clk);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("underrun_wait", {cs_n, sclk, tx_ready, busy}, 4'b0011);
      end
      @(posedge clk);
      #1;
      drive_byte(8'h34, 1'b1, a2);
      wait_idle();

      // INIT sequence
      init_req = 1'b1;
      @(negedge clk);
      chk("init_entry", {sr_load, tx_ready, cs_n}, 3'b101);
      chk("init_data", sr_data, {DB{1'b1}});
      @(posedge clk);
      #1 init_req = 1'b0;
      rises = 0;
      bad   = 0;
      ps    = 1'b0;
      for (int i = 1; i <= INIT_CLKS * CLK_DIV; i++) begin
         @(negedge clk);
         if (sclk && !ps) rises++;
         ps = sclk;
         if (tx_ready || !cs_n || !mosi || !busy) bad++;
      end
      chk("init_rises", rises, INIT_CLKS);
      chk("init_cond", bad, 0);
      @(negedge clk);
      chk("init_exit", {busy, tx_ready}, 2'b01);
      @(posedge clk);
      #1;

      // init_req and tx_valid together: INIT first, byte afterwards
      d        = 8'($urandom);
      init_req = 1'b1;
      tx_data  = d;
      tx_last  = 1'b1;
      tx_valid = 1'b1;
      @(negedge clk);
      t0 = cyc;
      chk("simul_ready", tx_ready, 1'b0);
      @(posedge clk);
      #1 init_req = 1'b0;
      drive_byte(d, 1'b1, a1);
      chk("simul_accept_cyc", a1 - t0, INIT_CLKS * CLK_DIV + 1);
      wait_idle();

      // Reset mid-byte at cycle 13
      tx_data  = 8'($urandom);
      tx_last  = 1'b1;
      tx_valid = 1'b1;
      @(negedge clk);
      chk("rst_accept", sr_load, 1'b1);
      @(posedge clk);
      #1 tx_valid = 1'b0;
      repeat (12) @(posedge clk);
      #3 n_rst = 1'b0;
      #1;
      chk("rst_async", {cs_n, sclk, busy}, 3'b100);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 n_rst = 1'b1;
      @(negedge clk);
      chk("rst_release", {tx_ready, busy, cs_n}, 3'b101);
      @(posedge clk);
      #1;

      // Random frames with random inter-byte gaps
      for (int f = 0; f < 20; f++) begin
         nb = $urandom_range(1, 4);
         for (int b = 0; b < nb; b++) begin
            drive_byte(8'($urandom), (b == nb - 1), a1);
            if (b < nb - 1) begin
               gap = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 45);
               repeat (gap) begin
                  @(posedge clk);
                  #1;
               end
            end
         end
         wait_idle();
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end

      repeat (5) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      chk("frames", frames, frames_exp);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
